if_fetch_stage: RTL and testbench

- Pipeline instruction-fetch stage directly upstream of the instruction-decode stage.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Delivers {instruction, pc, pc+4} to decode through a registered IF/ID output with a one-entry skid buffer.
- Supports decode back-pressure (stall) and redirects (taken branch or jump) with flush and wrong-path drop.

---
 rtl/if_fetch_stage.sv | 138 +++++++++++++
 tb/tb_if_fetch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction memory and
// feeds decode through a registered IF/ID stage backed by a one-entry skid buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    typedef enum logic [0:0] {StRun, StDrop} state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_fetch_pc, w_fetch_pc_next;
    logic [31:0] r_tgt_pc, w_tgt_pc_next;
    logic        r_buf_full, w_buf_full_next;
    logic [31:0] r_buf_ins, w_buf_ins_next;
    logic [31:0] r_buf_pc, w_buf_pc_next;
    logic        r_id_valid, w_id_valid_next;
    logic [31:0] r_id_ins, w_id_ins_next;
    logic [31:0] r_id_pc, w_id_pc_next;
    logic [31:0] r_id_pc4, w_id_pc4_next;

    logic        w_ack;
    logic        w_deliver;
    logic        w_loadable;

    // A full skid buffer stops fetching, so an ack never arrives while the buffer is occupied.
    assign imem_req   = !reset && ((r_state == StDrop) || !r_buf_full);
    assign imem_addr  = r_fetch_pc;
    assign w_ack      = imem_req && imem_ack;
    assign w_deliver  = w_ack && (r_state == StRun);
    assign w_loadable = !r_id_valid || !stall;

    assign id_valid = r_id_valid;
    assign id_ins   = r_id_ins;
    assign id_pc    = r_id_pc;
    assign id_pc4   = r_id_pc4;

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_tgt_pc_next   = r_tgt_pc;
        w_buf_full_next = r_buf_full;
        w_buf_ins_next  = r_buf_ins;
        w_buf_pc_next   = r_buf_pc;
        w_id_valid_next = r_id_valid;
        w_id_ins_next   = r_id_ins;
        w_id_pc_next    = r_id_pc;
        w_id_pc4_next   = r_id_pc4;

        if (redirect) begin
            w_id_valid_next = 1'b0;
            w_id_ins_next   = NOP_INS;
            w_buf_full_next = 1'b0;
            // An unacked request cannot be withdrawn: let it finish, then discard its data.
            if (imem_req && !imem_ack) begin
                w_state_next  = StDrop;
                w_tgt_pc_next = redirect_pc;
            end else begin
                w_state_next    = StRun;
                w_fetch_pc_next = redirect_pc;
            end
        end else if (r_state == StDrop) begin
            if (w_ack) begin
                w_state_next    = StRun;
                w_fetch_pc_next = r_tgt_pc;
            end
        end else begin
            if (w_deliver) begin
                w_fetch_pc_next = r_fetch_pc + 32'd4;
            end
            if (w_loadable) begin
                if (r_buf_full) begin
                    w_id_valid_next = 1'b1;
                    w_id_ins_next   = r_buf_ins;
                    w_id_pc_next    = r_buf_pc;
                    w_id_pc4_next   = r_buf_pc + 32'd4;
                    w_buf_full_next = w_deliver;
                    if (w_deliver) begin
                        w_buf_ins_next = imem_rdata;
                        w_buf_pc_next  = r_fetch_pc;
                    end
                end else if (w_deliver) begin
                    w_id_valid_next = 1'b1;
                    w_id_ins_next   = imem_rdata;
                    w_id_pc_next    = r_fetch_pc;
                    w_id_pc4_next   = r_fetch_pc + 32'd4;
                end else begin
                    w_id_valid_next = 1'b0;
                    w_id_ins_next   = NOP_INS;
                end
            end else if (w_deliver) begin
                w_buf_full_next = 1'b1;
                w_buf_ins_next  = imem_rdata;
                w_buf_pc_next   = r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StRun;
            r_fetch_pc <= RESET_PC;
            r_tgt_pc   <= RESET_PC;
            r_buf_full <= 1'b0;
            r_buf_ins  <= NOP_INS;
            r_buf_pc   <= 32'd0;
            r_id_valid <= 1'b0;
            r_id_ins   <= NOP_INS;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd4;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_tgt_pc   <= w_tgt_pc_next;
            r_buf_full <= w_buf_full_next;
            r_buf_ins  <= w_buf_ins_next;
            r_buf_pc   <= w_buf_pc_next;
            r_id_valid <= w_id_valid_next;
            r_id_ins   <= w_id_ins_next;
            r_id_pc    <= w_id_pc_next;
            r_id_pc4   <= w_id_pc4_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run against a queue-based
// model of the fetch stage.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INS  = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INS  (NOP_INS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ins      (id_ins),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetched-but-undelivered instructions live in a FIFO queue.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_tgt   = RESET_PC;
    logic        m_drop  = 1'b0;
    logic        m_idv   = 1'b0;
    logic [31:0] m_ins   = NOP_INS;
    logic [31:0] m_pc    = 32'd0;

    function automatic logic model_req(input logic rst);
        return !rst && (m_drop || (m_q.size() == 0));
    endfunction

    task automatic model_update(input logic rst, input logic stl, input logic rd,
                                input logic [31:0] rpc, input logic ack,
                                input logic [31:0] rdata);
        logic req;
        ent_t e;
        req = model_req(rst);
        if (rst) begin
            m_fetch = RESET_PC;
            m_drop  = 1'b0;
            m_q.delete();
            m_idv   = 1'b0;
            m_ins   = NOP_INS;
            m_pc    = 32'd0;
        end else if (rd) begin
            m_idv = 1'b0;
            m_ins = NOP_INS;
            m_q.delete();
            if (req && !ack) begin
                m_drop = 1'b1;
                m_tgt  = rpc;
            end else begin
                m_drop  = 1'b0;
                m_fetch = rpc;
            end
        end else begin
            if (req && ack) begin
                if (m_drop) begin
                    m_drop  = 1'b0;
                    m_fetch = m_tgt;
                end else begin
                    e.ins = rdata;
                    e.pc  = m_fetch;
                    m_q.push_back(e);
                    m_fetch = m_fetch + 32'd4;
                end
            end
            if (!m_idv || !stl) begin
                if (m_q.size() > 0) begin
                    e     = m_q.pop_front();
                    m_idv = 1'b1;
                    m_ins = e.ins;
                    m_pc  = e.pc;
                end else begin
                    m_idv = 1'b0;
                    m_ins = NOP_INS;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and advance the model; outputs settle #1 after.
    task automatic tick(input logic rst, input logic stl, input logic rd,
                        input logic [31:0] rpc, input logic ack, input logic [31:0] rdata);
        reset       = rst;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rdata;
        @(posedge clk);
        #1;
        model_update(rst, stl, rd, rpc, ack, rdata);
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'hdead_beef);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_req: got %0b want 0", imem_req);
        end
        n_checks++;
        if ({id_valid, id_ins, id_pc, id_pc4} !== {1'b0, NOP_INS, 32'd0, 32'd4}) begin
            n_errors++;
            $display("FAIL reset_id: got v=%0b ins=%h pc=%h pc4=%h want 0/%h/0/4",
                     id_valid, id_ins, id_pc, id_pc4, NOP_INS);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            n_errors++;
            $display("FAIL reset_release: got req=%0b addr=%h want 1/%h",
                     imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_zero_latency;
        logic [31:0] prog [5];
        logic [31:0] pc;
        prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113; prog[2] = 32'h0020_0193;
        prog[3] = 32'h0030_0213; prog[4] = 32'h0040_0293;
        for (int k = 0; k < 5; k++) begin
            pc = 32'(4 * k);
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, pc}) begin
                n_errors++;
                $display("FAIL zl_addr[%0d]: got req=%0b addr=%h want 1/%h",
                         k, imem_req, imem_addr, pc);
            end
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, prog[k]);
            n_checks++;
            if ({id_valid, id_ins, id_pc, id_pc4} !== {1'b1, prog[k], pc, pc + 32'd4}) begin
                n_errors++;
                $display("FAIL zl_id[%0d]: got v=%0b ins=%h pc=%h pc4=%h want 1/%h/%h/%h",
                         k, id_valid, id_ins, id_pc, id_pc4, prog[k], pc, pc + 32'd4);
            end
        end
    endtask

    task automatic test_latency3;
        logic [31:0] pc;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h14 + 32'(4 * k);
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, pc}) begin
                    n_errors++;
                    $display("FAIL lat3_addr[%0d.%0d]: got req=%0b addr=%h want 1/%h",
                             k, c, imem_req, imem_addr, pc);
                end
                tick(1'b0, 1'b0, 1'b0, 32'h0, c == 2, 32'h0A00_0000 | pc);
                if (c < 2) begin
                    n_checks++;
                    if ({id_valid, id_ins} !== {1'b0, NOP_INS}) begin
                        n_errors++;
                        $display("FAIL lat3_bubble[%0d.%0d]: got v=%0b ins=%h want 0/%h",
                                 k, c, id_valid, id_ins, NOP_INS);
                    end
                end else begin
                    n_checks++;
                    if ({id_valid, id_ins, id_pc} !== {1'b1, 32'h0A00_0000 | pc, pc}) begin
                        n_errors++;
                        $display("FAIL lat3_deliver[%0d]: got v=%0b ins=%h pc=%h want pc %h",
                                 k, id_valid, id_ins, id_pc, pc);
                    end
                end
            end
        end
    endtask

    task automatic test_stall;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0000);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0004);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hB000_0008);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({imem_req, id_valid, id_ins, id_pc} !== {1'b0, 1'b1, 32'hB000_0004, 32'h4}) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got req=%0b v=%0b ins=%h pc=%h want 0/1/B0000004/4",
                         c, imem_req, id_valid, id_ins, id_pc);
            end
            if (c < 3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if ({id_valid, id_ins, id_pc, imem_req, imem_addr} !==
            {1'b1, 32'hB000_0008, 32'h8, 1'b1, 32'hC}) begin
            n_errors++;
            $display("FAIL stall_release: got v=%0b ins=%h pc=%h req=%0b addr=%h want buf pc 8",
                     id_valid, id_ins, id_pc, imem_req, imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_000C);
        n_checks++;
        if ({id_valid, id_ins, id_pc} !== {1'b1, 32'hB000_000C, 32'hC}) begin
            n_errors++;
            $display("FAIL stall_next: got v=%0b ins=%h pc=%h want pc C", id_valid, id_ins, id_pc);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0010);
        n_checks++;
        if ({id_valid, id_ins, id_pc} !== {1'b1, 32'hB000_0010, 32'h10}) begin
            n_errors++;
            $display("FAIL stall_after: got v=%0b ins=%h pc=%h want pc 10", id_valid, id_ins, id_pc);
        end
    endtask

    task automatic test_redirect;
        // Redirect coinciding with an ack: the acked word must never reach decode.
        tick(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'hC000_0014);
        n_checks++;
        if ({id_valid, id_ins, imem_req, imem_addr} !== {1'b0, NOP_INS, 1'b1, 32'h100}) begin
            n_errors++;
            $display("FAIL redir_ack: got v=%0b ins=%h req=%0b addr=%h want 0/NOP/1/100",
                     id_valid, id_ins, imem_req, imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0100);
        n_checks++;
        if ({id_valid, id_ins, id_pc, id_pc4} !== {1'b1, 32'hC000_0100, 32'h100, 32'h104}) begin
            n_errors++;
            $display("FAIL redir_target: got v=%0b ins=%h pc=%h pc4=%h want pc 100",
                     id_valid, id_ins, id_pc, id_pc4);
        end
        // Redirects while a request is outstanding, then while already dropping.
        tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        n_checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h104, 1'b0}) begin
            n_errors++;
            $display("FAIL drop_hold: got req=%0b addr=%h v=%0b want 1/104/0",
                     imem_req, imem_addr, id_valid);
        end
        tick(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        n_checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h104, 1'b0}) begin
            n_errors++;
            $display("FAIL drop_rehold: got req=%0b addr=%h v=%0b want 1/104/0",
                     imem_req, imem_addr, id_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDDDD_0104);
        n_checks++;
        if ({imem_req, imem_addr, id_valid, id_ins} !== {1'b1, 32'h300, 1'b0, NOP_INS}) begin
            n_errors++;
            $display("FAIL drop_discard: got req=%0b addr=%h v=%0b ins=%h want 1/300/0/NOP",
                     imem_req, imem_addr, id_valid, id_ins);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC000_0300);
        n_checks++;
        if ({id_valid, id_ins, id_pc} !== {1'b1, 32'hC000_0300, 32'h300}) begin
            n_errors++;
            $display("FAIL drop_target: got v=%0b ins=%h pc=%h want pc 300", id_valid, id_ins, id_pc);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hE000_0304);
        n_checks++;
        if ({imem_req, id_pc} !== {1'b0, 32'h300}) begin
            n_errors++;
            $display("FAIL rmid_full: got req=%0b pc=%h want 0/300", imem_req, id_pc);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if ({imem_req, id_valid, id_ins, id_pc} !== {1'b0, 1'b0, NOP_INS, 32'h0}) begin
            n_errors++;
            $display("FAIL rmid_reset: got req=%0b v=%0b ins=%h pc=%h want 0/0/NOP/0",
                     imem_req, id_valid, id_ins, id_pc);
        end
        reset = 1'b0;
        stall = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            n_errors++;
            $display("FAIL rmid_addr: got req=%0b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_0000);
        n_checks++;
        if ({id_valid, id_ins, id_pc} !== {1'b1, 32'hF000_0000, RESET_PC}) begin
            n_errors++;
            $display("FAIL rmid_first: got v=%0b ins=%h pc=%h want F0000000 at reset pc",
                     id_valid, id_ins, id_pc);
        end
    endtask

    task automatic test_random;
        logic        rst, stl, rd, ack, req_now;
        logic [31:0] rpc;
        int          bad;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            stl = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 14) == 0);
            rpc = $urandom;
            req_now = model_req(rst);
            ack = req_now && ($urandom_range(0, 2) != 0);
            tick(rst, stl, rd, rpc, ack, $urandom);
            n_checks++;
            if ({imem_req, imem_addr, id_valid, id_ins, id_pc, id_pc4} !==
                {model_req(reset), m_fetch, m_idv, m_ins, m_pc, m_pc + 32'd4}) begin
                n_errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand[%0d]: got req=%0b addr=%h v=%0b ins=%h pc=%h pc4=%h want req=%0b addr=%h v=%0b ins=%h pc=%h",
                             c, imem_req, imem_addr, id_valid, id_ins, id_pc, id_pc4,
                             model_req(reset), m_fetch, m_idv, m_ins, m_pc);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        @(negedge clk);
        test_reset;
        test_zero_latency;
        test_latency3;
        test_stall;
        test_redirect;
        test_reset_mid;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
